// File: rtl/time_core.sv
// -----------------------------------------------------------------------------
// time_core
// Timekeeping and time-set core for the DE2 digital clock.
//
// Divides CLOCK_50 down to a 10 ms tick and keeps a packed-BCD calendar from
// centiseconds up to a four-digit year. A two-state machine (RUN / SET)
// driven by debounced one-cycle key pulses lets the user edit each BCD digit.
//
// Optional feature macro: LEAP_YEAR_EN
//   defined   - February has 29 days in leap years (decided on BCD digits)
//   undefined - February always has 28 days
//
// Parameters
//   CLK_HZ      input clock frequency; tick divisor = CLK_HZ / 100
// Ports
//   CLOCK_50    in   system clock, all logic on its rising edge
//   rst         in   asynchronous active-high reset
//   key_mode    in   pulse: toggle RUN / SET
//   key_sel     in   pulse: advance selected digit (SET only)
//   key_inc     in   pulse: increment selected digit (SET only)
//   adjust      out  1 = running, 0 = adjusting
//   select      out  index (0-15) of the digit being set
//   millisecond out  BCD centiseconds 00-99
//   second      out  BCD 00-59
//   minute      out  BCD 00-59
//   hour        out  BCD 00-23
//   day         out  BCD 01-31
//   month       out  BCD 01-12
//   year_l      out  BCD low two year digits
//   year_h      out  BCD high two year digits
// -----------------------------------------------------------------------------
module time_core #(
   parameter int CLK_HZ = 50_000_000
) (
   input  logic       CLOCK_50,
   input  logic       rst,
   input  logic       key_mode,
   input  logic       key_sel,
   input  logic       key_inc,
   output logic       adjust,
   output logic [3:0] select,
   output logic [7:0] millisecond,
   output logic [6:0] second,
   output logic [6:0] minute,
   output logic [5:0] hour,
   output logic [5:0] day,
   output logic [4:0] month,
   output logic [7:0] year_l,
   output logic [7:0] year_h
);

   localparam int TICK_DIV = CLK_HZ / 100;
   localparam int CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

   // Field order: 0 centisec, 1 sec, 2 min, 3 hour, 4 day, 5 month,
   // 6 year low, 7 year high. Digit index = 2*field + (tens ? 1 : 0).
   localparam logic [7:0] FIELD_RST [8] =
      '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h20};
   // Largest tens digit of each field before a SET increment wraps to 0.
   localparam logic [3:0] TENS_LAST [8] =
      '{4'd9, 4'd5, 4'd5, 4'd2, 4'd3, 4'd1, 4'd9, 4'd9};

   typedef enum logic {
      RUN = 1'b0,
      SET = 1'b1
   } state_t;

   state_t           state_reg, state_next;
   logic [3:0]       sel_reg, sel_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [7:0]       field_reg  [8];
   logic [7:0]       field_next [8];
   logic [7:0]       roll_field [8];
   logic [7:0]       inc_field  [8];
   logic [7:0]       dim;
   logic             tick;

   // Two-digit BCD increment: at or past 'last' it wraps to 'first' and
   // reports a carry into the next field.
   function automatic logic [8:0] bcd2_step(input logic [7:0] v,
                                            input logic [7:0] last,
                                            input logic [7:0] first);
      if (v >= last)
         return {1'b1, first};
      else if (v[3:0] >= 4'd9)
         return {1'b0, v[7:4] + 4'd1, 4'd0};
      else
         return {1'b0, v[7:4], v[3:0] + 4'd1};
   endfunction

`ifdef LEAP_YEAR_EN
   // Divisibility by 4 of a two-digit BCD number: the tens digit's parity
   // decides which units digits qualify.
   function automatic logic bcd_div4(input logic [7:0] v);
      if (!v[4])
         return (v[3:0] == 4'd0) || (v[3:0] == 4'd4) || (v[3:0] == 4'd8);
      else
         return (v[3:0] == 4'd2) || (v[3:0] == 4'd6);
   endfunction

   logic leap;
   assign leap = (field_reg[6] != 8'h00) ? bcd_div4(field_reg[6])
                                         : bcd_div4(field_reg[7]);
`endif

   // Days in the current month, BCD.
   always_comb begin
      dim = 8'h31;
      case (field_reg[5])
         8'h02: begin
`ifdef LEAP_YEAR_EN
            dim = leap ? 8'h29 : 8'h28;
`else
            dim = 8'h28;
`endif
         end
         8'h04, 8'h06, 8'h09, 8'h11: dim = 8'h30;
         default:                    dim = 8'h31;
      endcase
   end

   assign tick = (state_reg == RUN) && (cnt_reg == CNT_LAST);

   // Whole carry chain evaluated combinationally so a year rollover lands
   // on the single edge after the tick.
   always_comb begin
      logic       carry;
      logic [8:0] step;
      logic [7:0] last;
      logic [7:0] first;
      roll_field = field_reg;
      carry      = 1'b1;
      step       = '0;
      last       = 8'h99;
      first      = 8'h00;
      for (int i = 0; i < 8; i++) begin
         last  = 8'h99;
         first = 8'h00;
         case (i)
            1, 2: last = 8'h59;
            3:    last = 8'h23;
            4: begin
               last  = dim;
               first = 8'h01;
            end
            5: begin
               last  = 8'h12;
               first = 8'h01;
            end
            default: ;
         endcase
         if (carry) begin
            step          = bcd2_step(field_reg[i], last, first);
            roll_field[i] = step[7:0];
            carry         = step[8];
         end
      end
   end

   // Single-digit edit for SET mode: no carry between digits, then an
   // illegal hour/day/month falls back to its minimum.
   always_comb begin
      logic [2:0] idx;
      logic [7:0] cur;
      logic [7:0] upd;
      idx = sel_reg[3:1];
      cur = field_reg[idx];
      upd = cur;
      if (!sel_reg[0])
         upd[3:0] = (cur[3:0] >= 4'd9) ? 4'd0 : cur[3:0] + 4'd1;
      else
         upd[7:4] = (cur[7:4] >= TENS_LAST[idx]) ? 4'd0 : cur[7:4] + 4'd1;
      case (idx)
         3'd3: if (upd > 8'h23) upd = 8'h00;
         3'd4: if ((upd == 8'h00) || (upd > 8'h31)) upd = 8'h01;
         3'd5: if ((upd == 8'h00) || (upd > 8'h12)) upd = 8'h01;
         default: ;
      endcase
      inc_field      = field_reg;
      inc_field[idx] = upd;
   end

   // Next-state logic. key_mode has priority over the other keys and over
   // a coincident tick.
   always_comb begin
      state_next = state_reg;
      sel_next   = sel_reg;
      cnt_next   = cnt_reg;
      field_next = field_reg;
      case (state_reg)
         RUN: begin
            if (key_mode) begin
               state_next = SET;
               sel_next   = 4'd0;
               cnt_next   = '0;
            end else if (tick) begin
               cnt_next   = '0;
               field_next = roll_field;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         SET: begin
            cnt_next = '0;
            if (key_mode) begin
               state_next = RUN;
               // Editing may leave e.g. 31 April; clamp on exit.
               if (field_reg[4] > dim)
                  field_next[4] = dim;
            end else begin
               // Increment uses the old select even if key_sel is also set.
               if (key_inc)
                  field_next = inc_field;
               if (key_sel)
                  sel_next = sel_reg + 4'd1;
            end
         end
         default: state_next = RUN;
      endcase
   end

   always_ff @(posedge CLOCK_50 or posedge rst) begin
      if (rst) begin
         state_reg <= RUN;
         sel_reg   <= 4'd0;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         sel_reg   <= sel_next;
         cnt_reg   <= cnt_next;
      end
   end

   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_field
         always_ff @(posedge CLOCK_50 or posedge rst) begin
            if (rst)
               field_reg[gi] <= FIELD_RST[gi];
            else
               field_reg[gi] <= field_next[gi];
         end
      end
   endgenerate

   assign adjust      = (state_reg == RUN);
   assign select      = sel_reg;
   assign millisecond = field_reg[0];
   assign second      = field_reg[1][6:0];
   assign minute      = field_reg[2][6:0];
   assign hour        = field_reg[3][5:0];
   assign day         = field_reg[4][5:0];
   assign month       = field_reg[5][4:0];
   assign year_l      = field_reg[6];
   assign year_h      = field_reg[7];

endmodule

// File: tb/tb_time_core.sv
// -----------------------------------------------------------------------------
// tb_time_core
// Directed self-checking bench for time_core with CLK_HZ = 1000 (tick every
// 10 cycles). Inputs change 1 ns after the rising edge; outputs are sampled
// there too, well away from the next edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_time_core;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       key_mode = 1'b0;
   logic       key_sel = 1'b0;
   logic       key_inc = 1'b0;
   logic       adjust;
   logic [3:0] select;
   logic [7:0] millisecond;
   logic [6:0] second;
   logic [6:0] minute;
   logic [5:0] hour;
   logic [5:0] day;
   logic [4:0] month;
   logic [7:0] year_l;
   logic [7:0] year_h;

   int n_cmp = 0;
   int n_bad = 0;

   time_core #(.CLK_HZ(1000)) dut (
      .CLOCK_50    (clk),
      .rst         (rst),
      .key_mode    (key_mode),
      .key_sel     (key_sel),
      .key_inc     (key_inc),
      .adjust      (adjust),
      .select      (select),
      .millisecond (millisecond),
      .second      (second),
      .minute      (minute),
      .hour        (hour),
      .day         (day),
      .month       (month),
      .year_l      (year_l),
      .year_h      (year_h)
   );

   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end else begin
         $display("ok   %s: %0h", tag, obs);
      end
   endtask

   task automatic wait_edges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic press(input logic m, input logic s, input logic i);
      key_mode = m;
      key_sel  = s;
      key_inc  = i;
      @(posedge clk);
      #1;
      key_mode = 1'b0;
      key_sel  = 1'b0;
      key_inc  = 1'b0;
   endtask

   function automatic logic [7:0] get_field(input int fi);
      case (fi)
         0:       return millisecond;
         1:       return {1'b0, second};
         2:       return {1'b0, minute};
         3:       return {2'b0, hour};
         4:       return {2'b0, day};
         5:       return {3'b0, month};
         6:       return year_l;
         default: return year_h;
      endcase
   endfunction

   function automatic logic [3:0] get_digit(input int idx);
      logic [7:0] f;
      f = get_field(idx / 2);
      return (idx % 2 == 1) ? f[7:4] : f[3:0];
   endfunction

   task automatic goto_sel(input logic [3:0] n);
      for (int k = 0; k < 16; k++) begin
         if (select != n) press(1'b0, 1'b1, 1'b0);
      end
   endtask

   task automatic set_digit(input int idx, input logic [3:0] d);
      goto_sel(4'(idx));
      for (int k = 0; k < 12; k++) begin
         if (get_digit(idx) != d) press(1'b0, 1'b0, 1'b1);
      end
      check_value($sformatf("set_d%0d", idx), get_digit(idx), d);
   endtask

   // Units to 1 first keeps hour/day/month legal while the tens digit moves.
   task automatic set_field(input int fi, input logic [7:0] v);
      set_digit(2 * fi, 4'd1);
      set_digit(2 * fi + 1, v[7:4]);
      set_digit(2 * fi, v[3:0]);
   endtask

   task automatic set_datetime(input logic [7:0] yh, input logic [7:0] yl,
                               input logic [7:0] mo, input logic [7:0] d,
                               input logic [7:0] h, input logic [7:0] mi,
                               input logic [7:0] s, input logic [7:0] cs);
      set_field(0, cs);
      set_field(1, s);
      set_field(2, mi);
      set_field(3, h);
      set_field(4, d);
      set_field(5, mo);
      set_field(6, yl);
      set_field(7, yh);
   endtask

   // Leave SET from a xx:23:59:59.99 preload and check the date after one tick.
   task automatic leave_and_tick(input string tag, input logic [7:0] exp_d,
                                 input logic [7:0] exp_mo,
                                 input logic [7:0] exp_yl,
                                 input logic [7:0] exp_yh);
      press(1'b1, 1'b0, 1'b0);
      wait_edges(9);
      check_value({tag, "_pre_cs"}, millisecond, 8'h99);
      wait_edges(1);
      check_value({tag, "_cs"},    millisecond, 8'h00);
      check_value({tag, "_sec"},   second,      7'h00);
      check_value({tag, "_min"},   minute,      7'h00);
      check_value({tag, "_hour"},  hour,        6'h00);
      check_value({tag, "_day"},   day,         exp_d);
      check_value({tag, "_month"}, month,       exp_mo);
      check_value({tag, "_yl"},    year_l,      exp_yl);
      check_value({tag, "_yh"},    year_h,      exp_yh);
   endtask

   initial begin
      // Reset values
      #2 rst = 1'b1;
      @(posedge clk);
      #1;
      check_value("rst_adjust", adjust,      1'b1);
      check_value("rst_select", select,      4'd0);
      check_value("rst_cs",     millisecond, 8'h00);
      check_value("rst_sec",    second,      7'h00);
      check_value("rst_min",    minute,      7'h00);
      check_value("rst_hour",   hour,        6'h00);
      check_value("rst_day",    day,         6'h01);
      check_value("rst_month",  month,       5'h01);
      check_value("rst_yl",     year_l,      8'h00);
      check_value("rst_yh",     year_h,      8'h20);
      rst = 1'b0;

      // First tick: count 0..9, centiseconds change on the 10th edge
      wait_edges(9);
      check_value("tick_not_yet", millisecond, 8'h00);
      wait_edges(1);
      check_value("tick_first", millisecond, 8'h01);

      // Full rollover 1999-12-31 23:59:59.99 -> 2000-01-01
      press(1'b1, 1'b0, 1'b0);
      check_value("enter_set_adjust", adjust, 1'b0);
      set_datetime(8'h19, 8'h99, 8'h12, 8'h31, 8'h23, 8'h59, 8'h59, 8'h99);
      leave_and_tick("y2k", 8'h01, 8'h01, 8'h00, 8'h20);
      check_value("y2k_adjust", adjust, 1'b1);

      // February rollover in 2024
      press(1'b1, 1'b0, 1'b0);
      set_datetime(8'h20, 8'h24, 8'h02, 8'h28, 8'h23, 8'h59, 8'h59, 8'h99);
`ifdef LEAP_YEAR_EN
      leave_and_tick("feb2024", 8'h29, 8'h02, 8'h24, 8'h20);
      press(1'b1, 1'b0, 1'b0);
      set_datetime(8'h21, 8'h00, 8'h02, 8'h28, 8'h23, 8'h59, 8'h59, 8'h99);
      leave_and_tick("feb2100", 8'h01, 8'h03, 8'h00, 8'h21);
      press(1'b1, 1'b0, 1'b0);
      set_datetime(8'h20, 8'h00, 8'h02, 8'h28, 8'h23, 8'h59, 8'h59, 8'h99);
      leave_and_tick("feb2000", 8'h29, 8'h02, 8'h00, 8'h20);
`else
      leave_and_tick("feb2024", 8'h01, 8'h03, 8'h24, 8'h20);
`endif

      // Digit increments and legalisation in SET
      press(1'b1, 1'b0, 1'b0);
      set_field(3, 8'h19);
      goto_sel(4'd7);
      press(1'b0, 1'b0, 1'b1);
      check_value("hour29_to_00", hour, 6'h00);
      set_field(2, 8'h09);
      goto_sel(4'd4);
      press(1'b0, 1'b0, 1'b1);
      check_value("min09_to_00", minute, 7'h00);
      set_field(2, 8'h59);
      goto_sel(4'd4);
      press(1'b0, 1'b0, 1'b1);
      check_value("min59_to_50", minute, 7'h50);
      set_field(1, 8'h57);
      goto_sel(4'd3);
      press(1'b0, 1'b0, 1'b1);
      check_value("sec57_to_07", second, 7'h07);

      // Select wrapping and sel+inc together
      goto_sel(4'd5);
      repeat (16) press(1'b0, 1'b1, 1'b0);
      check_value("sel_16_presses", select, 4'd5);
      goto_sel(4'd15);
      press(1'b0, 1'b1, 1'b0);
      check_value("sel_15_to_0", select, 4'd0);
      set_field(0, 8'h38);
      goto_sel(4'd0);
      press(1'b0, 1'b1, 1'b1);
      check_value("selinc_cs", millisecond, 8'h39);
      check_value("selinc_select", select, 4'd1);

      // mode+inc together leaves SET without editing; April 31 clamps to 30
      set_datetime(8'h20, 8'h23, 8'h04, 8'h31, 8'h10, 8'h20, 8'h30, 8'h40);
      goto_sel(4'd3);
      press(1'b1, 1'b0, 1'b1);
      check_value("modeinc_adjust", adjust, 1'b1);
      check_value("modeinc_sec",    second, 7'h30);
      check_value("clamp_apr_day",  day,    6'h30);
      // RUN ignores sel/inc
      press(1'b0, 1'b1, 1'b1);
      check_value("run_ign_select", select,      4'd3);
      check_value("run_ign_sec",    second,      7'h30);
      check_value("run_ign_cs",     millisecond, 8'h40);
      // Now in the tick cycle; key_mode discards the tick
      wait_edges(8);
      check_value("pre_tick_cs", millisecond, 8'h40);
      press(1'b1, 1'b0, 1'b0);
      check_value("tick_drop_cs",     millisecond, 8'h40);
      check_value("tick_drop_adjust", adjust,      1'b0);
      check_value("enter_sel_zero",   select,      4'd0);

      // SET freezes time; Feb 31 clamps to 28 in 2023 (not a leap year)
      set_field(4, 8'h31);
      set_field(5, 8'h02);
      wait_edges(30);
      check_value("set_hold_cs", millisecond, 8'h40);
      press(1'b1, 1'b0, 1'b0);
      check_value("clamp_feb_day", day,    6'h28);
      check_value("clamp_feb_adj", adjust, 1'b1);

      // Asynchronous reset in SET, checked before any clock edge
      press(1'b1, 1'b0, 1'b0);
      set_field(3, 8'h15);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check_value("arst_adjust", adjust,      1'b1);
      check_value("arst_select", select,      4'd0);
      check_value("arst_cs",     millisecond, 8'h00);
      check_value("arst_hour",   hour,        6'h00);
      check_value("arst_day",    day,         6'h01);
      check_value("arst_month",  month,       5'h01);
      check_value("arst_yl",     year_l,      8'h00);
      check_value("arst_yh",     year_h,      8'h20);
      @(posedge clk);
      #1 rst = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
